// File: rtl/piso_shift_tx_if.sv
// rtl/piso_shift_tx_if.sv - load port and serial output bundle for piso_shift_tx
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             done;

  modport master (
    output load_valid, data_in,
    input  load_ready, ser_out, ser_valid, frame_start, done
  );

  modport slave (
    input  load_valid, data_in,
    output load_ready, ser_out, ser_valid, frame_start, done
  );
endinterface

// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in/serial-out transmitter, one bit per clk
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  piso_shift_tx_if.slave  bus
);

  localparam int CW      = $clog2(WIDTH + 1);
  localparam int SER_POS = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             last;
  logic             ready_c;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  // The outgoing bit always sits at SER_POS of shreg, so ser_out is a plain register bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      count <= count_n;
      shreg <= shreg_n;
`ifdef PISO_PARITY_EN
      if (accept) parity_q <= ^bus.data_in;
`endif
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    shreg_n = shreg;
    last    = 1'b0;

    case (state)
      SHIFT: begin
        if (count == LAST_CNT) begin
`ifdef PISO_PARITY_EN
          state_n          = PAR;
          shreg_n          = '0;
          shreg_n[SER_POS] = parity_q;
`else
          last = 1'b1;
`endif
        end else begin
          count_n = count + CW'(1);
          shreg_n = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        end
      end
`ifdef PISO_PARITY_EN
      PAR: last = 1'b1;
`endif
      default: ;
    endcase

    ready_c = (state == IDLE) || last;
    accept  = bus.load_valid && ready_c;

    // End of frame clears the shifter so ser_out idles low; a same-cycle load overrides.
    if (last) begin
      state_n = IDLE;
      shreg_n = '0;
    end
    if (accept) begin
      state_n = SHIFT;
      shreg_n = bus.data_in;
      count_n = '0;
    end
  end

  assign bus.load_ready  = !rst && ready_c;
  assign bus.ser_out     = shreg[SER_POS];
  assign bus.ser_valid   = (state != IDLE);
  assign bus.frame_start = (state == SHIFT) && (count == '0);
  assign bus.done        = last;

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb/tb_piso_shift_tx.sv - table-driven bench for piso_shift_tx (MSB-first and LSB-first instances)
module tb_piso_shift_tx;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  piso_shift_tx_if #(.WIDTH(8)) bus_m ();
  piso_shift_tx_if #(.WIDTH(8)) bus_l ();

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.slave));
  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [7:0] din;
    logic       ser_m;
    logic       ser_l;
    logic       valid;
    logic       fs;
    logic       done;
    logic       ready;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [7:0] din);
    bus_m.load_valid = lv;
    bus_m.data_in    = din;
    bus_l.load_valid = lv;
    bus_l.data_in    = din;
  endtask

  task automatic chk_all(input int idx, input logic sm, input logic sl, input logic v,
                         input logic fs, input logic dn, input logic rd);
    chk("ser_out_m", idx, bus_m.ser_out, sm);
    chk("ser_out_l", idx, bus_l.ser_out, sl);
    chk("ser_valid_m", idx, bus_m.ser_valid, v);
    chk("ser_valid_l", idx, bus_l.ser_valid, v);
    chk("frame_start_m", idx, bus_m.frame_start, fs);
    chk("frame_start_l", idx, bus_l.frame_start, fs);
    chk("done_m", idx, bus_m.done, dn);
    chk("done_l", idx, bus_l.done, dn);
    chk("load_ready_m", idx, bus_m.load_ready, rd);
    chk("load_ready_l", idx, bus_l.load_ready, rd);
  endtask

  task automatic add_idle(input logic lv, input logic [7:0] din);
    vec_t r;
    r.lv = lv; r.din = din;
    r.ser_m = 1'b0; r.ser_l = 1'b0; r.valid = 1'b0;
    r.fs = 1'b0; r.done = 1'b0; r.ready = 1'b1;
    vecs.push_back(r);
  endtask

  // seq_m / seq_l list the expected wire bits left to right in transmit order.
  task automatic add_frame(input logic [7:0] seq_m, input logic [7:0] seq_l, input logic par,
                           input logic lv_mid, input logic [7:0] din_mid,
                           input logic lv_last, input logic [7:0] din_last);
    vec_t r;
`ifdef PISO_PARITY_EN
    int n = 9;
`else
    int n = 8;
`endif
    for (int k = 0; k < n; k++) begin
      r.lv    = (k == n - 1) ? lv_last : lv_mid;
      r.din   = (k == n - 1) ? din_last : din_mid;
      r.ser_m = (k < 8) ? seq_m[7-k] : par;
      r.ser_l = (k < 8) ? seq_l[7-k] : par;
      r.valid = 1'b1;
      r.fs    = (k == 0);
      r.done  = (k == n - 1);
      r.ready = (k == n - 1);
      vecs.push_back(r);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 8'h00);

    // A5 single frame, then 01
    add_idle(1'b0, 8'h00);
    add_idle(1'b1, 8'hA5);
    add_frame(8'b1010_0101, 8'b1010_0101, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    add_idle(1'b1, 8'h01);
    add_frame(8'b0000_0001, 8'b1000_0000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    add_idle(1'b0, 8'h00);
    // back-to-back F0 then 0F; data_in changes mid-frame
    add_idle(1'b1, 8'hF0);
    add_frame(8'b1111_0000, 8'b0000_1111, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h0F);
    add_frame(8'b0000_1111, 8'b1111_0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    add_idle(1'b0, 8'h00);
    // FF offered during an 00 frame is taken only at the done cycle
    add_idle(1'b1, 8'h00);
    add_frame(8'b0000_0000, 8'b0000_0000, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF);
    add_frame(8'b1111_1111, 8'b1111_1111, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    add_idle(1'b0, 8'h00);
    // 07: odd number of ones, parity bit 1 when enabled
    add_idle(1'b1, 8'h07);
    add_frame(8'b0000_0111, 8'b1110_0000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    add_idle(1'b0, 8'h00);

    // reset state while rst is held
    #2;
    chk_all(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].lv, vecs[i].din);
      chk_all(i, vecs[i].ser_m, vecs[i].ser_l, vecs[i].valid,
              vecs[i].fs, vecs[i].done, vecs[i].ready);
    end

    // asynchronous reset in the middle of an A5 frame
    @(negedge clk);
    drive(1'b1, 8'hA5);
    @(negedge clk);
    drive(1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk_all(1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all(1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all(1002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_all(1003 + i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
